// File: rtl/voice_allocator.sv
// voice_allocator
//   Voice scheduler for the polyphonic synthesizer. Accepts MIDI note-on/off
//   events and scans the voice slots one per cycle to pick a target voice.
//   Allocation priority: retrigger a voice holding the key, first idle voice,
//   oldest releasing voice, then steal the oldest keyed voice.
//
//   Ports
//     reg_clk, reset_reg_n            clock, async active-low reset
//     ev_valid/ev_ready               event handshake
//     ev_on, ev_key, ev_vel           event payload (note-on vel 0 = note-off)
//     voice_free[VOICES]              per-voice envelope idle flags
//     sustain                         pedal level (SUSTAIN_PEDAL_EN only)
//     gate_valid/on/voice/key/vel     one-cycle gate command to the engine
//     steal                           gate retargets a voice holding another key
//     keys_on[VOICES], active_keys    held-key map and its popcount
//
//   Configuration macro: SUSTAIN_PEDAL_EN adds the sustain pedal input and
//   deferred release of sustained voices on the pedal falling edge.
module voice_allocator #(
  parameter int unsigned VOICES  = 32,
  parameter int unsigned V_WIDTH = 5,
  parameter int unsigned AGE_W   = 8
) (
  input  logic                 reg_clk,
  input  logic                 reset_reg_n,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic                 ev_on,
  input  logic [6:0]           ev_key,
  input  logic [6:0]           ev_vel,
  input  logic [VOICES-1:0]    voice_free,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                 sustain,
`endif
  output logic                 gate_valid,
  output logic                 gate_on,
  output logic [V_WIDTH-1:0]   gate_voice,
  output logic [6:0]           gate_key,
  output logic [6:0]           gate_vel,
  output logic                 steal,
  output logic [VOICES-1:0]    keys_on,
  output logic [V_WIDTH:0]     active_keys
);

  localparam int unsigned KEY_W = 7;
  localparam int unsigned CNT_W = V_WIDTH + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;
  typedef enum logic [1:0] {MODE_ON, MODE_OFF, MODE_PEDAL} mode_t;

  state_t                         r_state;
  mode_t                          r_mode;
  logic [V_WIDTH-1:0]             r_idx;
  logic [KEY_W-1:0]               r_ev_key;
  logic [KEY_W-1:0]               r_ev_vel;
  logic [VOICES-1:0][KEY_W-1:0]   r_key;
  logic [VOICES-1:0][AGE_W-1:0]   r_age;
  logic [VOICES-1:0]              r_keys_on;

  // Note-on scan candidates
  logic                           r_match_found;
  logic [V_WIDTH-1:0]             r_match_idx;
  logic                           r_idle_found;
  logic [V_WIDTH-1:0]             r_idle_idx;
  logic                           r_rel_found;
  logic [V_WIDTH-1:0]             r_rel_idx;
  logic [AGE_W-1:0]               r_rel_age;
  logic [V_WIDTH-1:0]             r_old_idx;
  logic [AGE_W-1:0]               r_old_age;

  logic                           r_ev_ready;
  logic                           r_gate_valid;
  logic                           r_gate_on;
  logic [V_WIDTH-1:0]             r_gate_voice;
  logic [KEY_W-1:0]               r_gate_key;
  logic [KEY_W-1:0]               r_gate_vel;
  logic                           r_steal;
  logic [CNT_W-1:0]               r_active_keys;

`ifdef SUSTAIN_PEDAL_EN
  logic [VOICES-1:0]              r_sustained;
  logic                           r_sus_d;
  logic                           r_sus_lat;
  logic                           r_pedal_pend;
  logic                           w_fall_now;
`endif

  logic [KEY_W-1:0]               w_cur_key;
  logic [AGE_W-1:0]               w_cur_age;
  logic                           w_cur_on;
  logic                           w_cur_held;
  logic                           w_cur_free;
  logic                           w_key_hit;
  logic                           w_last;
  logic                           w_ready_next;
  logic [V_WIDTH-1:0]             w_chosen;
  logic                           w_steal;
  logic [CNT_W-1:0]               w_popcnt;

  // Per-cycle view of the voice under inspection
  always_comb begin
    w_cur_key  = r_key[r_idx];
    w_cur_age  = r_age[r_idx];
    w_cur_on   = r_keys_on[r_idx];
    w_cur_free = voice_free[r_idx];
    w_key_hit  = (w_cur_key == r_ev_key);
    w_last     = (r_idx == V_WIDTH'(VOICES - 1));
`ifdef SUSTAIN_PEDAL_EN
    // A sustained voice still sounds its key, so a repeat note-on reclaims it
    w_cur_held   = w_cur_on | r_sustained[r_idx];
    w_fall_now   = r_sus_d & ~sustain;
    // Drop ready one cycle early so a pedal fall pre-empts a waiting event
    w_ready_next = ~w_fall_now;
`else
    w_cur_held   = w_cur_on;
    w_ready_next = 1'b1;
`endif
  end

  // Allocation priority resolved from the finished scan
  always_comb begin
    w_chosen = r_old_idx;
    if (r_match_found)     w_chosen = r_match_idx;
    else if (r_idle_found) w_chosen = r_idle_idx;
    else if (r_rel_found)  w_chosen = r_rel_idx;
    w_steal = r_keys_on[w_chosen] && (r_key[w_chosen] != r_ev_key);
  end

  // Held-key count
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < VOICES; i++) begin
      w_popcnt = w_popcnt + CNT_W'(r_keys_on[i]);
    end
  end

  // Control FSM, voice state and registered outputs
  always_ff @(posedge reg_clk or negedge reset_reg_n) begin
    if (!reset_reg_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_ON;
      r_idx         <= '0;
      r_ev_key      <= '0;
      r_ev_vel      <= '0;
      r_key         <= '0;
      r_age         <= '0;
      r_keys_on     <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_idle_found  <= 1'b0;
      r_idle_idx    <= '0;
      r_rel_found   <= 1'b0;
      r_rel_idx     <= '0;
      r_rel_age     <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      r_ev_ready    <= 1'b1;
      r_gate_valid  <= 1'b0;
      r_gate_on     <= 1'b0;
      r_gate_voice  <= '0;
      r_gate_key    <= '0;
      r_gate_vel    <= '0;
      r_steal       <= 1'b0;
      r_active_keys <= '0;
`ifdef SUSTAIN_PEDAL_EN
      r_sustained   <= '0;
      r_sus_d       <= 1'b0;
      r_sus_lat     <= 1'b0;
      r_pedal_pend  <= 1'b0;
`endif
    end else begin
      r_gate_valid  <= 1'b0;
      r_steal       <= 1'b0;
      r_active_keys <= w_popcnt;
`ifdef SUSTAIN_PEDAL_EN
      r_sus_d <= sustain;
`endif
      case (r_state)
        ST_IDLE: begin
`ifdef SUSTAIN_PEDAL_EN
          if (r_pedal_pend) begin
            r_pedal_pend <= 1'b0;
            r_mode       <= MODE_PEDAL;
            r_idx        <= '0;
            r_ev_ready   <= 1'b0;
            r_state      <= ST_SCAN;
          end else
`endif
          if (ev_valid && r_ev_ready) begin
            r_ev_key      <= ev_key;
            r_ev_vel      <= ev_vel;
            r_mode        <= (ev_on && (ev_vel != '0)) ? MODE_ON : MODE_OFF;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_idle_found  <= 1'b0;
            r_rel_found   <= 1'b0;
            r_rel_age     <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_ev_ready    <= 1'b0;
            r_state       <= ST_SCAN;
`ifdef SUSTAIN_PEDAL_EN
            r_sus_lat     <= sustain;
`endif
          end else begin
            r_ev_ready <= w_ready_next;
          end
        end

        ST_SCAN: begin
          case (r_mode)
            MODE_ON: begin
              if (!r_match_found && w_cur_held && w_key_hit) begin
                r_match_found <= 1'b1;
                r_match_idx   <= r_idx;
              end
              if (!r_idle_found && !w_cur_on && w_cur_free) begin
                r_idle_found <= 1'b1;
                r_idle_idx   <= r_idx;
              end
              // Strict compare keeps the lowest index on age ties
              if (!w_cur_on && (!r_rel_found || (w_cur_age > r_rel_age))) begin
                r_rel_found <= 1'b1;
                r_rel_idx   <= r_idx;
                r_rel_age   <= w_cur_age;
              end
              if (w_cur_age > r_old_age) begin
                r_old_idx <= r_idx;
                r_old_age <= w_cur_age;
              end
            end
            MODE_OFF: begin
              if (w_cur_on && w_key_hit) begin
                r_keys_on[r_idx] <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
                if (r_sus_lat) begin
                  r_sustained[r_idx] <= 1'b1;
                end else
`endif
                begin
                  r_gate_valid <= 1'b1;
                  r_gate_on    <= 1'b0;
                  r_gate_voice <= r_idx;
                  r_gate_key   <= r_ev_key;
                  r_gate_vel   <= '0;
                end
              end
            end
`ifdef SUSTAIN_PEDAL_EN
            MODE_PEDAL: begin
              if (r_sustained[r_idx]) begin
                r_sustained[r_idx] <= 1'b0;
                r_gate_valid       <= 1'b1;
                r_gate_on          <= 1'b0;
                r_gate_voice       <= r_idx;
                r_gate_key         <= w_cur_key;
                r_gate_vel         <= '0;
              end
            end
`endif
            default: ;
          endcase
          if (w_last) begin
            r_idx   <= '0;
            r_state <= (r_mode == MODE_ON) ? ST_COMMIT : ST_IDLE;
          end else begin
            r_idx <= r_idx + V_WIDTH'(1);
          end
        end

        ST_COMMIT: begin
          r_gate_valid        <= 1'b1;
          r_gate_on           <= 1'b1;
          r_gate_voice        <= w_chosen;
          r_gate_key          <= r_ev_key;
          r_gate_vel          <= r_ev_vel;
          r_steal             <= w_steal;
          r_keys_on[w_chosen] <= 1'b1;
          r_key[w_chosen]     <= r_ev_key;
`ifdef SUSTAIN_PEDAL_EN
          r_sustained[w_chosen] <= 1'b0;
`endif
          // Chosen voice becomes youngest; everything else ages, saturating
          for (int i = 0; i < VOICES; i++) begin
            if (V_WIDTH'(i) == w_chosen) begin
              r_age[i] <= '0;
            end else if (r_age[i] != AGE_MAX) begin
              r_age[i] <= r_age[i] + AGE_W'(1);
            end
          end
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
`ifdef SUSTAIN_PEDAL_EN
      // Placed last so a fresh fall is never lost to a pend clear
      if (w_fall_now) r_pedal_pend <= 1'b1;
`endif
    end
  end

  assign ev_ready    = r_ev_ready;
  assign gate_valid  = r_gate_valid;
  assign gate_on     = r_gate_on;
  assign gate_voice  = r_gate_voice;
  assign gate_key    = r_gate_key;
  assign gate_vel    = r_gate_vel;
  assign steal       = r_steal;
  assign keys_on     = r_keys_on;
  assign active_keys = r_active_keys;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Directed bench for voice_allocator (32 voices). Expected values are
//   hand-derived from the allocation rules and cycle timing of the block.
module tb_voice_allocator;

  logic        reg_clk = 1'b0;
  logic        reset_reg_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_key;
  logic [6:0]  ev_vel;
  logic [31:0] voice_free;
`ifdef SUSTAIN_PEDAL_EN
  logic        sustain;
`endif
  logic        gate_valid;
  logic        gate_on;
  logic [4:0]  gate_voice;
  logic [6:0]  gate_key;
  logic [6:0]  gate_vel;
  logic        steal;
  logic [31:0] keys_on;
  logic [5:0]  active_keys;

  int errors = 0;
  int checks = 0;

  // Results of the last event
  int          g_ngates;
  int          g_lat;
  int          g_rdy;
  logic [4:0]  g_voice;
  logic        g_on;
  logic [6:0]  g_key;
  logic [6:0]  g_vel;
  logic        g_steal;

  voice_allocator dut (
    .reg_clk     (reg_clk),
    .reset_reg_n (reset_reg_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .voice_free  (voice_free),
`ifdef SUSTAIN_PEDAL_EN
    .sustain     (sustain),
`endif
    .gate_valid  (gate_valid),
    .gate_on     (gate_on),
    .gate_voice  (gate_voice),
    .gate_key    (gate_key),
    .gate_vel    (gate_vel),
    .steal       (steal),
    .keys_on     (keys_on),
    .active_keys (active_keys)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one event and follow it until ev_ready returns (bounded)
  task automatic run_event(input logic on, input logic [6:0] key, input logic [6:0] vel);
    int w;
    w = 0;
    while (!ev_ready && w < 60) begin
      tick();
      w++;
    end
    chk("ready_before_event", 32'(ev_ready), 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = key;
    ev_vel   = vel;
    tick();
    ev_valid = 1'b0;
    g_ngates = 0;
    g_lat    = 0;
    g_rdy    = 0;
    g_voice  = '0;
    g_on     = 1'b0;
    g_key    = '0;
    g_vel    = '0;
    g_steal  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (gate_valid) begin
        g_ngates++;
        if (g_ngates == 1) begin
          g_lat   = c;
          g_voice = gate_voice;
          g_on    = gate_on;
          g_key   = gate_key;
          g_vel   = gate_vel;
          g_steal = steal;
        end
      end
      if (ev_ready) begin
        g_rdy = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_reg_n = 1'b0;
    tick();
    tick();
    reset_reg_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    reset_reg_n = 1'b0;
    ev_valid    = 1'b0;
    ev_on       = 1'b0;
    ev_key      = '0;
    ev_vel      = '0;
    voice_free  = '1;
`ifdef SUSTAIN_PEDAL_EN
    sustain     = 1'b0;
`endif
    tick();
    tick();
    // Reset values
    chk("rst_ready", 32'(ev_ready), 32'd1);
    chk("rst_gate_valid", 32'(gate_valid), 32'd0);
    chk("rst_steal", 32'(steal), 32'd0);
    chk("rst_keys_on", keys_on, 32'd0);
    chk("rst_active", 32'(active_keys), 32'd0);
    reset_reg_n = 1'b1;
    tick();

    // Reset asserted mid-scan abandons the event
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd60; ev_vel = 7'd50;
    tick();
    ev_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("midscan_ready_low", 32'(ev_ready), 32'd0);
    reset_reg_n = 1'b0;
    tick();
    reset_reg_n = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gate_valid) n++;
    end
    chk("midscan_no_gate", 32'(n), 32'd0);
    chk("midscan_keys_on", keys_on, 32'd0);
    chk("midscan_active", 32'(active_keys), 32'd0);
    chk("midscan_ready", 32'(ev_ready), 32'd1);

    // First note-on goes to voice 0
    run_event(1'b1, 7'd60, 7'd100);
    chk("on60_ngates", 32'(g_ngates), 32'd1);
    chk("on60_latency", 32'(g_lat), 32'd33);
    chk("on60_voice", 32'(g_voice), 32'd0);
    chk("on60_gate_on", 32'(g_on), 32'd1);
    chk("on60_key", 32'(g_key), 32'd60);
    chk("on60_vel", 32'(g_vel), 32'd100);
    chk("on60_steal", 32'(g_steal), 32'd0);
    chk("on60_ready_lat", 32'(g_rdy), 32'd34);
    chk("on60_keys_on", keys_on, 32'h1);
    chk("on60_active", 32'(active_keys), 32'd1);

    // Retrigger of a held key
    run_event(1'b1, 7'd60, 7'd80);
    chk("retrig_voice", 32'(g_voice), 32'd0);
    chk("retrig_steal", 32'(g_steal), 32'd0);
    chk("retrig_vel", 32'(g_vel), 32'd80);
    chk("retrig_active", 32'(active_keys), 32'd1);

    // Note-off releases voice 0 in the cycle after it is inspected
    run_event(1'b0, 7'd60, 7'd64);
    chk("off60_ngates", 32'(g_ngates), 32'd1);
    chk("off60_latency", 32'(g_lat), 32'd1);
    chk("off60_voice", 32'(g_voice), 32'd0);
    chk("off60_gate_on", 32'(g_on), 32'd0);
    chk("off60_key", 32'(g_key), 32'd60);
    chk("off60_vel", 32'(g_vel), 32'd0);
    chk("off60_ready_lat", 32'(g_rdy), 32'd33);
    chk("off60_keys_on", keys_on, 32'h0);
    chk("off60_active", 32'(active_keys), 32'd0);

    // Note-on with velocity 0 acts as note-off
    run_event(1'b1, 7'd60, 7'd90);
    chk("reheld_voice", 32'(g_voice), 32'd0);
    run_event(1'b1, 7'd60, 7'd0);
    chk("vel0_ngates", 32'(g_ngates), 32'd1);
    chk("vel0_gate_on", 32'(g_on), 32'd0);
    chk("vel0_voice", 32'(g_voice), 32'd0);
    chk("vel0_keys_on", keys_on, 32'h0);

    // First idle voice needs voice_free
    voice_free = ~32'h3;
    run_event(1'b1, 7'd10, 7'd70);
    chk("free_voice", 32'(g_voice), 32'd2);
    chk("free_keys_on", keys_on, 32'h4);

    // Note-off with no matching key gives no strobe
    run_event(1'b0, 7'd11, 7'd0);
    chk("nomatch_ngates", 32'(g_ngates), 32'd0);
    chk("nomatch_ready_lat", 32'(g_rdy), 32'd33);

    run_event(1'b0, 7'd10, 7'd0);
    chk("off10_voice", 32'(g_voice), 32'd2);
    chk("off10_latency", 32'(g_lat), 32'd3);

    // No idle voice: oldest releasing (ages v0=1 v2=0 others=4 -> v1)
    voice_free = '0;
    run_event(1'b1, 7'd20, 7'd40);
    chk("oldrel_voice", 32'(g_voice), 32'd1);
    chk("oldrel_steal", 32'(g_steal), 32'd0);
    run_event(1'b0, 7'd20, 7'd0);
    chk("off20_voice", 32'(g_voice), 32'd1);
    chk("off20_latency", 32'(g_lat), 32'd2);

    // Fill every voice: key k lands in voice k
    voice_free = '1;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      run_event(1'b1, 7'(k), 7'(k + 1));
      if (g_voice != 5'(k)) n++;
    end
    chk("fill_misplaced", 32'(n), 32'd0);
    chk("fill_keys_on", keys_on, 32'hFFFF_FFFF);
    chk("fill_active", 32'(active_keys), 32'd32);

    // All keyed: steal the oldest (voice 0)
    run_event(1'b1, 7'd100, 7'd127);
    chk("steal_voice", 32'(g_voice), 32'd0);
    chk("steal_flag", 32'(g_steal), 32'd1);
    chk("steal_key", 32'(g_key), 32'd100);
    chk("steal_active", 32'(active_keys), 32'd32);
    chk("steal_keys_on", keys_on, 32'hFFFF_FFFF);

    // Retrigger in a full pool is not a steal
    run_event(1'b1, 7'd5, 7'd9);
    chk("full_retrig_voice", 32'(g_voice), 32'd5);
    chk("full_retrig_steal", 32'(g_steal), 32'd0);

    run_event(1'b0, 7'd100, 7'd0);
    chk("off100_voice", 32'(g_voice), 32'd0);
    chk("off100_active", 32'(active_keys), 32'd31);

`ifdef SUSTAIN_PEDAL_EN
    // Sustained note-off is deferred until the pedal falls
    do_reset();
    run_event(1'b1, 7'd60, 7'd100);
    chk("sus_on_voice", 32'(g_voice), 32'd0);
    sustain = 1'b1;
    tick();
    tick();
    run_event(1'b0, 7'd60, 7'd0);
    chk("sus_off_ngates", 32'(g_ngates), 32'd0);
    chk("sus_off_keys_on", keys_on, 32'h0);
    sustain = 1'b0;
    n = 0;
    g_voice = '1;
    g_on = 1'b1;
    g_key = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gate_valid) begin
        n++;
        g_voice = gate_voice;
        g_on = gate_on;
        g_key = gate_key;
      end
    end
    chk("pedal_ngates", 32'(n), 32'd1);
    chk("pedal_voice", 32'(g_voice), 32'd0);
    chk("pedal_gate_on", 32'(g_on), 32'd0);
    chk("pedal_key", 32'(g_key), 32'd60);
    chk("pedal_ready", 32'(ev_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
